mario_score_text: RTL

MARIO_SCORE_TEXT -- requirements
Module: mario_score_text

---
 rtl/mario_pkg.sv | 56 +++++
 rtl/mario_score_text_bin2bcd.sv | 46 ++++
 rtl/mario_score_text.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/mario_pkg.sv
// Shared layout and ASCII constants for the score/level/lives text row,
// plus the conversion FSM state type.
package mario_pkg;

    localparam int XCHARS_DEF = 69;

    localparam logic [7:0] SCORE_LBL_COL = 8'd0;
    localparam logic [7:0] SCORE_DIG_COL = 8'd6;
    localparam logic [7:0] LEVEL_LBL_COL = 8'd30;
    localparam logic [7:0] LEVEL_DIG_COL = 8'd36;
    localparam logic [7:0] LIVES_LBL_COL = 8'd58;
    localparam logic [7:0] LIVES_DIG_COL = 8'd64;
    localparam logic [7:0] LBL_LEN       = 8'd5;

    localparam logic [6:0] ASCII_SPACE = 7'h20;
    localparam logic [6:0] ASCII_ZERO  = 7'h30;

    localparam logic [39:0] SCORE_STR = "SCORE";
    localparam logic [39:0] LEVEL_STR = "LEVEL";
    localparam logic [39:0] LIVES_STR = "LIVES";

    typedef enum logic [2:0] {
        IDLE,
        CONV_SCORE,
        CONV_LEVEL,
        CONV_LIVES,
        WRITE
    } state_t;

    // Character i (0 = leftmost) of a 5-character label.
    function automatic logic [6:0] label_char(input logic [39:0] s, input logic [7:0] i);
        case (i)
            8'd0:    return s[38:32];
            8'd1:    return s[30:24];
            8'd2:    return s[22:16];
            8'd3:    return s[14:8];
            default: return s[6:0];
        endcase
    endfunction

    function automatic logic [6:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO | {3'b000, d};
    endfunction

    // BCD digit k counted from the least significant nibble.
    function automatic logic [3:0] bcd_digit(input logic [19:0] v, input logic [2:0] k);
        case (k)
            3'd0:    return v[3:0];
            3'd1:    return v[7:4];
            3'd2:    return v[11:8];
            3'd3:    return v[15:12];
            default: return v[19:16];
        endcase
    endfunction

endpackage

// File: rtl/mario_score_text_bin2bcd.sv
// Sequential double-dabble: one load cycle then 16 shift/add-3 cycles.
module bin2bcd (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] bin,
    output logic [19:0] bcd,
    output logic        done,
    output logic        active
);

    logic [15:0] sr;
    logic [19:0] acc;
    logic [19:0] adj;
    logic [4:0]  cnt;

    always_comb begin
        adj = acc;
        for (int i = 0; i < 5; i++) begin
            if (acc[4*i +: 4] > 4'd4)
                adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (start) begin
            sr  <= bin;
            acc <= '0;
            cnt <= 5'd16;
        end else if (cnt != 5'd0) begin
            acc <= {adj[18:0], sr[15]};
            sr  <= {sr[14:0], 1'b0};
            cnt <= cnt - 5'd1;
        end
    end

    // done marks the cycle performing the final shift; bcd is valid the cycle after.
    assign done   = (cnt == 5'd1);
    assign active = (cnt != 5'd0);
    assign bcd    = acc;

endmodule

// File: rtl/mario_score_text.sv
// Score/level/lives text row: converts the inputs to BCD in the background and
// swaps the new digits onto the display only at a vsync rising edge.
module mario_score_text
    import mario_pkg::*;
#(
    parameter int XCHARS = XCHARS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] score,
    input  logic [7:0]  level,
    input  logic [3:0]  lives,
    input  logic        update,
    input  logic        vsync_in,
    input  logic [7:0]  char_xy,
    output logic [6:0]  char_code,
    output logic        busy
);

    localparam logic [7:0] XCHARS_W = 8'(XCHARS);

    state_t state, state_nxt;

    logic [15:0] score_r;
    logic [7:0]  level_r;
    logic [3:0]  lives_r;
    logic        req, pending, vs_q, vs_rise;
    logic [19:0] score_tmp, sh_score, dp_score;
    logic [11:0] level_tmp, sh_level, dp_level;
    logic [7:0]  sh_lives, dp_lives;

    logic        cv_start, cv_done, cv_active;
    logic [15:0] cv_in;
    logic [19:0] cv_bcd;

    logic [6:0]  char_nxt;
    logic [7:0]  off_sl, off_sd, off_ll, off_ld, off_vl, off_vd;

    bin2bcd u_conv (
        .clk    (clk),
        .rst    (rst),
        .start  (cv_start),
        .bin    (cv_in),
        .bcd    (cv_bcd),
        .done   (cv_done),
        .active (cv_active)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (update || req) state_nxt = CONV_SCORE;
            CONV_SCORE: if (cv_done) state_nxt = CONV_LEVEL;
            CONV_LEVEL: if (cv_done) state_nxt = CONV_LIVES;
            CONV_LIVES: if (cv_done) state_nxt = WRITE;
            WRITE:      state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Each CONV state's first cycle is the one where the converter is idle.
    always_comb begin
        busy     = (state != IDLE);
        cv_start = 1'b0;
        cv_in    = 16'h0000;
        case (state)
            CONV_SCORE: begin cv_start = ~cv_active; cv_in = score_r; end
            CONV_LEVEL: begin cv_start = ~cv_active; cv_in = {8'h00, level_r}; end
            CONV_LIVES: begin cv_start = ~cv_active; cv_in = {12'h000, lives_r}; end
            default: ;
        endcase
    end

    assign vs_rise = vsync_in & ~vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            score_r   <= '0;
            level_r   <= '0;
            lives_r   <= '0;
            req       <= 1'b0;
            pending   <= 1'b0;
            vs_q      <= 1'b0;
            score_tmp <= '0;
            level_tmp <= '0;
            sh_score  <= '0;
            sh_level  <= '0;
            sh_lives  <= '0;
            dp_score  <= '0;
            dp_level  <= '0;
            dp_lives  <= '0;
        end else begin
            vs_q <= vsync_in;
            if (state == IDLE && (update || req)) begin
                score_r <= score;
                level_r <= level;
                lives_r <= lives;
                req     <= 1'b0;
            end else if (state != IDLE && update) begin
                req <= 1'b1;
            end
            // Previous field's result is still on the converter output while it reloads.
            if (state == CONV_LEVEL && cv_start) score_tmp <= cv_bcd;
            if (state == CONV_LIVES && cv_start) level_tmp <= cv_bcd[11:0];
            // A WRITE coinciding with a vsync edge defers the commit to the next edge.
            if (state == WRITE) begin
                sh_score <= score_tmp;
                sh_level <= level_tmp;
                sh_lives <= cv_bcd[7:0];
                pending  <= 1'b1;
            end else if (vs_rise && pending) begin
                dp_score <= sh_score;
                dp_level <= sh_level;
                dp_lives <= sh_lives;
                pending  <= 1'b0;
            end
        end
    end

    always_comb begin
        off_sl   = char_xy - SCORE_LBL_COL;
        off_sd   = char_xy - SCORE_DIG_COL;
        off_ll   = char_xy - LEVEL_LBL_COL;
        off_ld   = char_xy - LEVEL_DIG_COL;
        off_vl   = char_xy - LIVES_LBL_COL;
        off_vd   = char_xy - LIVES_DIG_COL;
        char_nxt = ASCII_SPACE;
        // Offsets wrap below the field start, so one unsigned compare bounds both sides.
        if (char_xy < XCHARS_W) begin
            if (off_sl < LBL_LEN)
                char_nxt = label_char(SCORE_STR, off_sl);
            else if (off_sd < 8'd5)
                char_nxt = digit_char(bcd_digit(dp_score, 3'd4 - off_sd[2:0]));
            else if (off_ll < LBL_LEN)
                char_nxt = label_char(LEVEL_STR, off_ll);
            else if (off_ld < 8'd3)
                char_nxt = digit_char(bcd_digit({8'h00, dp_level}, 3'd2 - off_ld[2:0]));
            else if (off_vl < LBL_LEN)
                char_nxt = label_char(LIVES_STR, off_vl);
            else if (off_vd < 8'd2)
                char_nxt = digit_char(bcd_digit({12'h000, dp_lives}, 3'd1 - off_vd[2:0]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) char_code <= ASCII_SPACE;
        else     char_code <= char_nxt;
    end

endmodule
